pipe_sched: RTL and testbench

Round-robin scheduler and flow controller for the shared 3-stage arithmetic pipeline that computes E = 5A + 5B − 4C + 3D, where D is the pipeline's internal constant 768. It arbitrates N_REQ requesters onto the single datapath, drives the datapath's global `stall`, and tracks a valid/ID shadow pipeline in lock-step with the datapath stages. It presents results on one ready/valid output port tagged with the originating requester. It sits between the requester blocks and the datapath instance, with the datapath's A/B/C inputs and E output wired through it.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/pipe_sched.sv | 98 +++++++++
 tb/tb_pipe_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and the shadow-stage record for the E = 5A + 5B - 4C + 3D pipeline scheduler.
package pipe_pkg;

  localparam int unsigned PIPE_DEPTH = 3;
  localparam int unsigned OPND_W     = 8;
  localparam int unsigned RES_W      = 16;
  localparam int unsigned ID_MAX_W   = 3;

  // Sized for the largest supported requester count (8); instances with fewer requesters use a narrower copy.
  typedef struct packed {
    logic                v;
    logic [ID_MAX_W-1:0] id;
  } shadow_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the stored pointer, which moves past the winner on each accepted grant.
module rr_arbiter
  import pipe_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  index
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_cand;
  logic            w_found;

  always_comb begin
    grant   = '0;
    index   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_cand = ID_W'((32'(r_ptr) + k) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found       = 1'b1;
        grant[w_cand] = 1'b1;
        index         = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= ID_W'((32'(index) + 1) % N_REQ);
    end
  end

endmodule

// File: rtl/pipe_sched.sv
// Scheduler and flow controller for the shared 3-stage arithmetic datapath: arbitration, operand mux,
// valid/ID shadow pipeline, global stall and the downstream result counter.
module pipe_sched
  import pipe_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [OPND_W*N_REQ-1:0] req_a,
  input  logic [OPND_W*N_REQ-1:0] req_b,
  input  logic [OPND_W*N_REQ-1:0] req_c,
  output logic [OPND_W-1:0]       dp_a,
  output logic [OPND_W-1:0]       dp_b,
  output logic [OPND_W-1:0]       dp_c,
  output logic                    dp_stall,
  input  logic [RES_W-1:0]        dp_e,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RES_W-1:0]        out_e,
  output logic [ID_W-1:0]         out_id,
  output logic [RES_W-1:0]        done_cnt
);

  // Same layout as pipe_pkg::shadow_t, with the ID cut to this instance's width.
  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } stage_t;

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic             w_stall;
  logic             w_accept;
  stage_t           r_sh [PIPE_DEPTH];
  logic [RES_W-1:0] r_done;

  assign w_any    = |w_grant;
  assign w_stall  = r_sh[PIPE_DEPTH-1].v & ~out_ready;
  // Gating with rst keeps req_ready low while reset is held, even with requests pending.
  assign w_accept = w_any & ~w_stall & rst;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (w_accept),
    .grant   (w_grant),
    .index   (w_idx)
  );

  assign req_ready = w_grant & {N_REQ{~w_stall & rst}};

  always_comb begin
    dp_a = '0;
    dp_b = '0;
    dp_c = '0;
    if (w_any) begin
      dp_a = req_a[OPND_W*w_idx +: OPND_W];
      dp_b = req_b[OPND_W*w_idx +: OPND_W];
      dp_c = req_c[OPND_W*w_idx +: OPND_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        r_sh[i] <= '0;
      end
      r_done <= '0;
    end else begin
      if (!w_stall) begin
        r_sh[0].v  <= w_any;
        r_sh[0].id <= w_idx;
        for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
          r_sh[i] <= r_sh[i-1];
        end
      end
      if (r_sh[PIPE_DEPTH-1].v && out_ready) begin
        r_done <= r_done + 1'b1;
      end
    end
  end

  assign dp_stall  = w_stall;
  assign out_valid = r_sh[PIPE_DEPTH-1].v;
  assign out_id    = r_sh[PIPE_DEPTH-1].id;
  assign out_e     = dp_e;
  assign done_cnt  = r_done;

endmodule

// File: tb/tb_pipe_sched.sv
// Bench for pipe_sched: an emulated 3-stage datapath, a slot-level reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_pipe_sched;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [15:0] req_a = '0, req_b = '0, req_c = '0;
  logic [7:0]  dp_a, dp_b, dp_c;
  logic        dp_stall;
  logic [15:0] dp_e;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_e;
  logic [0:0]  out_id;
  logic [15:0] done_cnt;

  always #5 clk = ~clk;

  pipe_sched #(.N_REQ(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_stall(dp_stall), .dp_e(dp_e),
    .out_valid(out_valid), .out_ready(out_ready), .out_e(out_e), .out_id(out_id),
    .done_cnt(done_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [15:0] calc(input int a, input int b, input int c);
    return 16'(5*a + 5*b - 4*c + 3*768);
  endfunction

  function automatic int opnd(input logic [15:0] bus, input int i);
    logic [15:0] t;
    t = bus >> (8*i);
    return int'(t[7:0]);
  endfunction

  function automatic int mgrant(input logic [1:0] rv, input int ptr);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (rv[c]) return c;
    end
    return -1;
  endfunction

  // Emulated datapath: three frozen-on-stall stages driven by the scheduler's operand outputs.
  logic [15:0] e_st [3];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_st[0] <= '0; e_st[1] <= '0; e_st[2] <= '0;
    end else if (!dp_stall) begin
      e_st[0] <= calc(int'(dp_a), int'(dp_b), int'(dp_c));
      e_st[1] <= e_st[0];
      e_st[2] <= e_st[1];
    end
  end
  assign dp_e = e_st[2];

  // Reference model: three slots that advance unless the last holds an unaccepted result.
  int         m_v [3];
  int         m_id[3];
  int         m_e [3];
  int         m_ptr;
  int         m_done;
  int         m_g;
  bit         m_st;
  logic [1:0] acc_last;

  always_comb m_g = mgrant(req_valid, m_ptr);
  always_comb m_st = (m_v[2] != 0) && !out_ready;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_v[i] <= 0; m_id[i] <= 0; m_e[i] <= 0;
      end
      m_ptr    <= 0;
      m_done   <= 0;
      acc_last <= '0;
    end else begin
      if (m_v[2] != 0 && out_ready) m_done <= m_done + 1;
      acc_last <= '0;
      if (!m_st) begin
        m_v[1] <= m_v[0]; m_id[1] <= m_id[0]; m_e[1] <= m_e[0];
        m_v[2] <= m_v[1]; m_id[2] <= m_id[1]; m_e[2] <= m_e[1];
        if (m_g >= 0) begin
          m_v[0]  <= 1;
          m_id[0] <= m_g;
          m_e[0]  <= int'(calc(opnd(req_a, m_g), opnd(req_b, m_g), opnd(req_c, m_g)));
          m_ptr   <= (m_g + 1) % N;
          acc_last[m_g] <= 1'b1;
        end else begin
          m_v[0] <= 0; m_id[0] <= 0; m_e[0] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      logic [1:0] exp_rdy;
      exp_rdy = '0;
      if (m_g >= 0 && !m_st) exp_rdy[m_g] = 1'b1;
      check("out_valid", 32'(out_valid), 32'(m_v[2] != 0));
      if (m_v[2] != 0) begin
        check("out_id", 32'(out_id), 32'(m_id[2]));
        check("out_e", 32'(out_e), 32'(m_e[2]));
      end
      check("dp_stall", 32'(dp_stall), 32'(m_st));
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("done_cnt", 32'(done_cnt), 32'(16'(m_done)));
      if (m_g >= 0) begin
        check("dp_a", 32'(dp_a), 32'(opnd(req_a, m_g)));
        check("dp_b", 32'(dp_b), 32'(opnd(req_b, m_g)));
        check("dp_c", 32'(dp_c), 32'(opnd(req_c, m_g)));
      end
    end
  end

  // Logs of what the DUT actually accepted and delivered, for the literal checks.
  int g_log[$];
  int o_id[$];
  int o_e[$];
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) g_log.push_back(i);
      if (out_valid && out_ready) begin
        o_id.push_back(int'(out_id));
        o_e.push_back(int'(out_e));
      end
    end
  end

  int pend[2] = '{0, 0};

  // One clock: requesters drop valid once all their pending requests have been accepted.
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_last[i] && pend[i] > 0) pend[i]--;
      req_valid[i] = (pend[i] > 0);
    end
  endtask

  initial begin
    req_a = {8'd10, 8'd1};
    req_b = {8'd20, 8'd2};
    req_c = {8'd5, 8'd3};
    #2 rst = 1'b0;
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst dp_stall", 32'(dp_stall), 32'd0);
    check("rst done_cnt", 32'(done_cnt), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst out_id", 32'(out_id), 32'd0);
    rst = 1'b1;
    req_valid = 2'b00;

    // Single request from port 0.
    @(posedge clk); #1;
    pend[0] = 1; req_valid = 2'b01;
    cyc();
    cyc();
    cyc();
    check("single out_valid", 32'(out_valid), 32'd1);
    check("single out_e", 32'(out_e), 32'd2307);
    check("single out_id", 32'(out_id), 32'd0);
    cyc();
    check("single done_cnt", 32'(done_cnt), 32'd1);

    // Port 1 alone, then idle: the next contended grant must go to port 0.
    pend[1] = 1; req_valid = 2'b10;
    cyc();
    repeat (3) cyc();
    g_log.delete(); o_id.delete(); o_e.delete();
    pend[0] = 3; pend[1] = 3; req_valid = 2'b11;
    repeat (6) cyc();
    repeat (4) cyc();
    check("contention grants", 32'(g_log.size()), 32'd6);
    for (int k = 0; k < 6 && k < g_log.size(); k++) check("grant order", 32'(g_log[k]), 32'(k % 2));
    check("contention results", 32'(o_id.size()), 32'd6);
    for (int k = 0; k < 6 && k < o_id.size(); k++) begin
      check("result id", 32'(o_id[k]), 32'(k % 2));
      check("result e", 32'(o_e[k]), (k % 2) ? 32'd2434 : 32'd2307);
    end
    check("contention done_cnt", 32'(done_cnt), 32'd8);

    // Backpressure with three in flight; port 1 waits and is accepted on the release cycle.
    o_id.delete(); o_e.delete();
    pend[0] = 3; req_valid = 2'b01;
    repeat (3) cyc();
    check("bp out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    pend[1] = 1; req_valid[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp dp_stall", 32'(dp_stall), 32'd1);
      check("bp req_ready", 32'(req_ready), 32'd0);
      check("bp out_id", 32'(out_id), 32'd0);
      check("bp out_e", 32'(out_e), 32'd2307);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    check("release req_ready", 32'(req_ready), 32'd2);
    repeat (5) cyc();
    check("bp results", 32'(o_id.size()), 32'd4);
    for (int k = 0; k < 4 && k < o_id.size(); k++) check("bp result id", 32'(o_id[k]), (k == 3) ? 32'd1 : 32'd0);
    check("bp done_cnt", 32'(done_cnt), 32'd12);

    // Reset with results in flight.
    pend[0] = 4; req_valid = 2'b01;
    repeat (4) cyc();
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid-reset out_valid", 32'(out_valid), 32'd0);
    check("mid-reset done_cnt", 32'(done_cnt), 32'd0);
    check("mid-reset dp_stall", 32'(dp_stall), 32'd0);
    pend[0] = 0; pend[1] = 0; req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("post-reset out_valid", 32'(out_valid), 32'd0);
    end
    check("post-reset done_cnt", 32'(done_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d expected 0 pending", 1);
    $fatal(1, "timeout");
  end

endmodule
